// File: rtl/branch_pkg.sv
// Shared encodings for the branch sequencing controller: 2-bit counter states,
// their reset value, the recovery FSM states and the saturating update rule.
package branch_pkg;

   localparam logic [1:0] CTR_SNT   = 2'b00;
   localparam logic [1:0] CTR_WNT   = 2'b01;
   localparam logic [1:0] CTR_WT    = 2'b10;
   localparam logic [1:0] CTR_ST    = 2'b11;
   localparam logic [1:0] CTR_RESET = CTR_WNT;

   typedef enum logic {
      IDLE    = 1'b0,
      RECOVER = 1'b1
   } state_t;

   function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
      if (taken) begin
         return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
      end
      return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
   endfunction

endpackage

// File: rtl/branch_flush_ctrl_if.sv
// IF-predict / EX-resolve / flush-redirect signal bundle between the pipeline
// (master) and the branch flush controller (slave).
interface branch_flush_ctrl_if #(
   parameter int PC_W = 32
);
   logic            if_valid;
   logic            if_is_branch;
   logic [PC_W-1:0] if_pc;
   logic [PC_W-1:0] if_target;
   logic            pred_taken;
   logic [PC_W-1:0] pred_pc;
   logic            ex_valid;
   logic [PC_W-1:0] ex_pc;
   logic [PC_W-1:0] ex_target;
   logic            ex_pred_taken;
   logic            branch_out;
   logic            flush;
   logic            redirect_valid;
   logic [PC_W-1:0] redirect_pc;

   modport master (
      output if_valid, if_is_branch, if_pc, if_target,
      output ex_valid, ex_pc, ex_target, ex_pred_taken, branch_out,
      input  pred_taken, pred_pc, flush, redirect_valid, redirect_pc
   );

   modport slave (
      input  if_valid, if_is_branch, if_pc, if_target,
      input  ex_valid, ex_pc, ex_target, ex_pred_taken, branch_out,
      output pred_taken, pred_pc, flush, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/bht_2bit.sv
// Table of 2-bit saturating branch counters: combinational read, synchronous
// update. Only built when BRANCH_PREDICT_EN is defined.
`ifdef BRANCH_PREDICT_EN
module bht_2bit
   import branch_pkg::*;
#(
   parameter int IDX_BITS = 6
) (
   input  logic                Clk,
   input  logic                Rst_n,
   input  logic [IDX_BITS-1:0] rd_idx,
   output logic                rd_taken,
   input  logic                wr_en,
   input  logic [IDX_BITS-1:0] wr_idx,
   input  logic                wr_taken
);
   localparam int DEPTH = 1 << IDX_BITS;

   logic [1:0] ctr_reg [DEPTH];
   logic [1:0] ctr_next;

   assign ctr_next = ctr_update(ctr_reg[wr_idx], wr_taken);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            ctr_reg[i] <= CTR_RESET;
         end
      end else if (wr_en) begin
         ctr_reg[wr_idx] <= ctr_next;
      end
   end

   // Read sees the pre-update value when IF and EX hit the same entry.
   assign rd_taken = ctr_reg[rd_idx][1];

endmodule
`endif

// File: rtl/branch_flush_ctrl.sv
// Branch predict/resolve controller with one-cycle flush and PC redirect.
// BRANCH_PREDICT_EN selects the 2-bit counter predictor; otherwise static not-taken.
module branch_flush_ctrl
   import branch_pkg::*;
#(
   parameter int IDX_BITS = 6,
   parameter int PC_W     = 32
) (
   input logic                Clk,
   input logic                Rst_n,
   branch_flush_ctrl_if.slave bus
);
   state_t          state_reg, state_next;
   logic            resolve;
   logic            mispredict;
   logic            predict_taken;
   logic            recover_out;
   logic [PC_W-1:0] correct_pc;
   logic [PC_W-1:0] redirect_pc_reg, redirect_pc_next;

   // EX is wrong-path while recovering, so it is only looked at in IDLE.
   assign resolve    = (state_reg == IDLE) && bus.ex_valid;
   assign correct_pc = bus.branch_out ? bus.ex_target : bus.ex_pc + PC_W'(4);

`ifdef BRANCH_PREDICT_EN
   logic ctr_taken;

   bht_2bit #(
      .IDX_BITS(IDX_BITS)
   ) u_bht (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .rd_idx   (bus.if_pc[IDX_BITS+1:2]),
      .rd_taken (ctr_taken),
      .wr_en    (resolve),
      .wr_idx   (bus.ex_pc[IDX_BITS+1:2]),
      .wr_taken (bus.branch_out)
   );

   assign predict_taken  = bus.if_valid & bus.if_is_branch & ctr_taken;
   assign mispredict     = resolve && (bus.branch_out != bus.ex_pred_taken);
   assign bus.pred_pc    = predict_taken ? bus.if_target : bus.if_pc + PC_W'(4);
`else
   logic unused_pred;

   assign unused_pred    = ^{bus.if_valid, bus.if_is_branch, bus.if_target, bus.ex_pred_taken};
   assign predict_taken  = 1'b0;
   assign mispredict     = resolve && bus.branch_out;
   assign bus.pred_pc    = bus.if_pc + PC_W'(4);
`endif

   assign bus.pred_taken = predict_taken;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_reg       <= IDLE;
         redirect_pc_reg <= '0;
      end else begin
         state_reg       <= state_next;
         redirect_pc_reg <= redirect_pc_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      redirect_pc_next = redirect_pc_reg;
      recover_out      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (mispredict) begin
               state_next       = RECOVER;
               redirect_pc_next = correct_pc;
            end
         end
         RECOVER: begin
            recover_out = 1'b1;
            state_next  = IDLE;
         end
      endcase
   end

   assign bus.flush          = recover_out;
   assign bus.redirect_valid = recover_out;
   assign bus.redirect_pc    = redirect_pc_reg;

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// Directed-vector bench for branch_flush_ctrl; covers the static build and,
// when BRANCH_PREDICT_EN is defined, the counter predictor.
module tb_branch_flush_ctrl;
   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   branch_flush_ctrl_if #(.PC_W(32)) bus ();

   branch_flush_ctrl #(
      .IDX_BITS(6),
      .PC_W    (32)
   ) dut (
      .Clk   (clk),
      .Rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      $display("vec %0d %s observed=%h expected=%h", vectors, tag, obs, exp);
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] pc, input logic [31:0] tgt);
      bus.if_valid     = 1'b1;
      bus.if_is_branch = 1'b1;
      bus.if_pc        = pc;
      bus.if_target    = tgt;
      #1;
   endtask

   task automatic resolve(input logic [31:0] pc, input logic [31:0] tgt,
                          input logic pred, input logic outcome);
      bus.ex_valid      = 1'b1;
      bus.ex_pc         = pc;
      bus.ex_target     = tgt;
      bus.ex_pred_taken = pred;
      bus.branch_out    = outcome;
   endtask

   task automatic ex_idle();
      bus.ex_valid      = 1'b0;
      bus.ex_pred_taken = 1'b0;
      bus.branch_out    = 1'b0;
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      rst_n        = 1'b0;
      bus.if_valid = 1'b0;
      bus.if_is_branch = 1'b0;
      bus.if_pc    = '0;
      bus.if_target = '0;
      bus.ex_pc    = '0;
      bus.ex_target = '0;
      ex_idle();

      // Reset state
      #12;
      fetch(32'h40, 32'h100);
      chk("rst_flush", 32'(bus.flush), 32'd0);
      chk("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
      chk("rst_redirect_pc", bus.redirect_pc, 32'h0);
      chk("rst_pred_taken", 32'(bus.pred_taken), 32'd0);
      chk("rst_pred_pc", bus.pred_pc, 32'h44);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      fetch(32'h40, 32'h100);
      chk("post_rst_pred_taken", 32'(bus.pred_taken), 32'd0);
      chk("post_rst_pred_pc", bus.pred_pc, 32'h44);

      fetch(32'hFFFF_FFFC, 32'h10);
      bus.if_is_branch = 1'b0;
      #1;
      chk("wrap_pred_pc", bus.pred_pc, 32'h0);

      // Taken branch predicted not-taken
      resolve(32'h40, 32'h100, 1'b0, 1'b1);
      #1;
      chk("mp_before_edge_flush", 32'(bus.flush), 32'd0);
      tick();
      chk("mp_flush", 32'(bus.flush), 32'd1);
      chk("mp_redirect_valid", 32'(bus.redirect_valid), 32'd1);
      chk("mp_redirect_pc", bus.redirect_pc, 32'h100);

      // Mismatching EX during RECOVER must be ignored
      resolve(32'h80, 32'h200, 1'b0, 1'b1);
      tick();
      ex_idle();
      chk("rec_ign_flush", 32'(bus.flush), 32'd0);
      chk("rec_ign_redirect_valid", 32'(bus.redirect_valid), 32'd0);
      chk("rec_ign_redirect_pc", bus.redirect_pc, 32'h100);
      tick();
      chk("rec_ign_flush_later", 32'(bus.flush), 32'd0);

`ifdef BRANCH_PREDICT_EN
      fetch(32'h40, 32'h100);
      chk("trained_pred_taken", 32'(bus.pred_taken), 32'd1);
      chk("trained_pred_pc", bus.pred_pc, 32'h100);
      fetch(32'h140, 32'h500);
      chk("alias_pred_taken", 32'(bus.pred_taken), 32'd1);
      chk("alias_pred_pc", bus.pred_pc, 32'h500);
      fetch(32'h80, 32'h200);
      chk("rec_ign_ctr_0x80", 32'(bus.pred_taken), 32'd0);
      chk("rec_ign_pc_0x80", bus.pred_pc, 32'h84);

      // Saturate 0x40 at strong-taken with correct predictions
      for (int k = 0; k < 3; k++) begin
         resolve(32'h40, 32'h100, 1'b1, 1'b1);
         tick();
         chk("sat_no_flush", 32'(bus.flush), 32'd0);
      end
      resolve(32'h40, 32'h100, 1'b1, 1'b0);
      tick();
      chk("sat_nt_flush", 32'(bus.flush), 32'd1);
      chk("sat_nt_redirect_pc", bus.redirect_pc, 32'h44);
      resolve(32'h40, 32'h100, 1'b1, 1'b0);
      tick();
      ex_idle();
      chk("sat_rec_ign_flush", 32'(bus.flush), 32'd0);
      fetch(32'h40, 32'h100);
      chk("sat_still_taken", 32'(bus.pred_taken), 32'd1);
      chk("sat_still_pc", bus.pred_pc, 32'h100);

      // Reset while recovering from a 0x80 mispredict
      resolve(32'h80, 32'h200, 1'b0, 1'b1);
      tick();
      ex_idle();
      chk("rmr_flush_set", 32'(bus.flush), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rmr_flush", 32'(bus.flush), 32'd0);
      chk("rmr_redirect_valid", 32'(bus.redirect_valid), 32'd0);
      chk("rmr_redirect_pc", bus.redirect_pc, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      fetch(32'h40, 32'h100);
      chk("rmr_pred_taken", 32'(bus.pred_taken), 32'd0);
      chk("rmr_pred_pc", bus.pred_pc, 32'h44);
`else
      fetch(32'h40, 32'h100);
      chk("static_pred_taken", 32'(bus.pred_taken), 32'd0);
      chk("static_pred_pc", bus.pred_pc, 32'h44);

      resolve(32'h40, 32'h100, 1'b0, 1'b0);
      tick();
      chk("static_nt_no_flush", 32'(bus.flush), 32'd0);
      resolve(32'h40, 32'h100, 1'b1, 1'b0);
      tick();
      chk("static_nt_pred1_no_flush", 32'(bus.flush), 32'd0);

      // Reset while recovering
      resolve(32'h80, 32'h200, 1'b0, 1'b1);
      tick();
      ex_idle();
      chk("rmr_flush_set", 32'(bus.flush), 32'd1);
      chk("rmr_redirect_pc_set", bus.redirect_pc, 32'h200);
      rst_n = 1'b0;
      #1;
      chk("rmr_flush", 32'(bus.flush), 32'd0);
      chk("rmr_redirect_valid", 32'(bus.redirect_valid), 32'd0);
      chk("rmr_redirect_pc", bus.redirect_pc, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Taken branch at 0x40 flushes every time
      for (int k = 0; k < 2; k++) begin
         fetch(32'h40, 32'h100);
         chk("static_repeat_pred", 32'(bus.pred_taken), 32'd0);
         resolve(32'h40, 32'h100, 1'b0, 1'b1);
         tick();
         ex_idle();
         chk("static_repeat_flush", 32'(bus.flush), 32'd1);
         chk("static_repeat_redirect_pc", bus.redirect_pc, 32'h100);
         tick();
         chk("static_repeat_flush_drop", 32'(bus.flush), 32'd0);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/branch_flush_ctrl.md
# branch_flush_ctrl

Branch sequencing controller for the 5-stage MIPS pipeline. It predicts branches fetched in IF using a table of 2-bit saturating counters, and compares each prediction against the taken/not-taken result that `BranchLogic` (`branch_out`) produces in EX. On a mismatch it issues a one-cycle registered flush and a PC redirect, then updates the predictor table.

## Interface
Parameters:
- `IDX_BITS`, 6: predictor index width; the table holds 2^IDX_BITS counters.
- `PC_W`, 32: PC width.

Ports:
- `Clk`  in  1  pipeline clock; all state updates on the rising edge.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `if_valid`  in  1  IF holds a valid instruction this cycle.
- `if_is_branch`  in  1  predecoded conditional branch in IF.
- `if_pc`  in  PC_W  PC of the IF instruction.
- `if_target`  in  PC_W  branch target of the IF instruction.
- `pred_taken`  out  1  prediction sent to the PC mux; also carried down the pipeline.
- `pred_pc`  out  PC_W  next fetch PC.
- `ex_valid`  in  1  a conditional branch is resolving in EX.
- `ex_pc`  in  PC_W  PC of the EX branch.
- `ex_target`  in  PC_W  target of the EX branch.
- `ex_pred_taken`  in  1  the prediction made for this branch in IF.
- `branch_out`  in  1  actual outcome from `BranchLogic`.
- `flush`  out  1  kills the IF, ID and EX instructions.
- `redirect_valid`  out  1  PC must load `redirect_pc`.
- `redirect_pc`  out  PC_W  correct-path PC.

## Operation
- Table index is `pc[IDX_BITS+1:2]`.
- Each counter encodes 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- **Predict** (combinational):
  - `pred_taken = if_valid & if_is_branch & ctr[idx][1]`.
  - `pred_pc = pred_taken ? if_target : if_pc + 4`. The addition is PC_W bits and wraps modulo 2^PC_W.
- **Resolve** happens only in state IDLE with `ex_valid`=1.
  - mispredict = `branch_out != ex_pred_taken`.
  - Correct PC = `branch_out ? ex_target : ex_pc + 4`.
- **Counter update** in the same cycle:
  - Taken: increment, saturating at 11.
  - Not taken: decrement, saturating at 00.
- **FSM states**:
  - IDLE → RECOVER on mispredict. The redirect registers are loaded on that edge.
  - RECOVER → IDLE unconditionally after one cycle.
- **RECOVER behaviour**:
  - `flush`=1 and `redirect_valid`=1.
  - `ex_valid` is ignored because the EX instruction is wrong-path: no counter update, no new mispredict.
- **Simultaneous predict and update to the same index**: the prediction uses the pre-update value (no bypass).
- **Aliasing**: PCs with equal index bits share one counter. This is intentional; there are no tags.
- **Reset values**:
  - State IDLE, `flush`=0, `redirect_valid`=0, `redirect_pc`=0.
  - All counters 01, so `pred_taken`=0 and `pred_pc`=`if_pc`+4.
- **Reset asserted mid-RECOVER**: `flush` and `redirect_valid` drop immediately (asynchronously) and the counters reinitialise.

## Timing
- Prediction has zero-cycle latency: combinational from the IF inputs.
- Mispredict detected in cycle N gives `flush`/`redirect_valid`/`redirect_pc` in cycle N+1, exactly one cycle wide.
- In N+1 the branch is in MEM. The pipeline kills EX/ID/IF, and the PC loads `redirect_pc` at the end of N+1.
- Penalty is 3 cycles per mispredict. Correct predictions cost 0 cycles.
- Back-to-back mispredicts are impossible: the earliest next flush is at N+3.

## Configuration
- `BRANCH_PREDICT_EN` defined:
  - The counter table and dynamic prediction are compiled in, as described above.
- `BRANCH_PREDICT_EN` undefined (static not-taken):
  - No table; `pred_taken`=0 and `pred_pc`=`if_pc`+4 always.
  - mispredict = `ex_valid & branch_out` in IDLE.
  - The FSM and redirect timing are unchanged.

## Structure
- Shared package `branch_pkg` holds:
  - Counter encodings `CTR_SNT`/`CTR_WNT`/`CTR_WT`/`CTR_ST`.
  - Reset value `CTR_RESET = CTR_WNT`.
  - FSM state enum `IDLE`/`RECOVER`.
- Sub-module `bht_2bit` contains the table:
  - One combinational read port (IF index) and one synchronous write port (EX index, taken bit).
  - Asynchronous reset to `CTR_RESET`.
  - Excluded entirely when `BRANCH_PREDICT_EN` is undefined.

## Test plan
- **Reset prediction:** after reset, IF branch at 0x40 with target 0x100 → `pred_taken`=0, `pred_pc`=0x44; `flush`=0.
- **Taken mispredict:** EX resolves pc 0x40, `ex_pred_taken`=0, `branch_out`=1, target 0x100.
  - Next cycle: `flush`=1, `redirect_pc`=0x100 for exactly one cycle.
  - Then IF fetch of 0x40 → `pred_taken`=1, `pred_pc`=0x100.
- **Saturation:** three correct taken resolves at 0x40 → no flush, counter 11. Then one not-taken with `ex_pred_taken`=1:
  - `flush` and `redirect_pc`=0x44.
  - Counter 10; 0x40 still predicts taken.
- **RECOVER ignores EX:** present a mismatching `ex_valid` during the RECOVER cycle → no second flush and no counter change (verify by re-fetching that PC).
- **Aliasing (IDX_BITS=6):** train 0x40 to taken → fetch 0x140 also predicts taken (shared index 16).
- **Reset mid-recovery:** assert `Rst_n`=0 during RECOVER → `flush`=0 immediately; after release, 0x40 predicts not-taken. Repeat with the macro undefined: `pred_taken` stays 0 and the taken branch at 0x40 flushes every time.
